// File: rtl/sysram_uart_dump_if.sv
// ---------------------------------------------------------------------------
// sysram_uart_dump_if
//   Bundles the two data-path ports of the sysRAM dump engine: the sysRAM
//   read port and the 64-bit UART transmitter data/valid/ready port.
//
//   master : the dump engine (drives read strobe/address and tx frame/valid)
//   slave  : the RAM + UART side (returns read data and tx ready)
//
//   O_ram_rd_en  master->slave  one-cycle read strobe
//   O_ram_addr   master->slave  word address, valid with O_ram_rd_en
//   I_ram_rdata  slave->master  read data, RD_LAT cycles after the strobe
//   O_tx_data    master->slave  64-bit frame
//   O_tx_en      master->slave  one-cycle frame-valid pulse
//   I_tx_ready   slave->master  transmitter idle/ready
// ---------------------------------------------------------------------------
interface sysram_uart_dump_if #(
  parameter int ADDR_W = 16
);
  logic              O_ram_rd_en;
  logic [ADDR_W-1:0] O_ram_addr;
  logic [31:0]       I_ram_rdata;
  logic [63:0]       O_tx_data;
  logic              O_tx_en;
  logic              I_tx_ready;

  modport master (
    output O_ram_rd_en, O_ram_addr, O_tx_data, O_tx_en,
    input  I_ram_rdata, I_tx_ready
  );

  modport slave (
    input  O_ram_rd_en, O_ram_addr, O_tx_data, O_tx_en,
    output I_ram_rdata, I_tx_ready
  );
endinterface

// File: rtl/sysram_uart_dump.sv
// ---------------------------------------------------------------------------
// sysram_uart_dump
//   On a start pulse, reads I_len consecutive 32-bit words from sysRAM
//   starting at I_start_addr, packs each pair big-endian into a 64-bit frame
//   (earlier address in [63:32]) and hands the frames to the UART
//   transmitter. An odd count pads the low half of the last frame with
//   PAD_WORD. Everything runs on the 10 MHz UART clock, which also clocks the
//   sysRAM read port.
//
//   I_clk_10M     clock
//   I_rst_n       asynchronous active-low reset
//   I_start       start pulse, only looked at in IDLE
//   I_start_addr  first word address
//   I_len         number of 32-bit words to send (0 = no reads, no frames)
//   O_busy        high from the accepted start until O_done
//   O_done        one-cycle completion pulse
//   bus           sysRAM read port + UART tx port (master side)
// ---------------------------------------------------------------------------
module sysram_uart_dump #(
  parameter int          ADDR_W   = 16,
  parameter int          LEN_W    = 16,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] PAD_WORD = 32'h0,
  parameter int          HOLDOFF  = 2
) (
  input  logic              I_clk_10M,
  input  logic              I_rst_n,
  input  logic              I_start,
  input  logic [ADDR_W-1:0] I_start_addr,
  input  logic [LEN_W-1:0]  I_len,
  output logic              O_busy,
  output logic              O_done,
  sysram_uart_dump_if.master bus
);

  // Wait counter runs 0..RD_LAT, hold counter runs 0..HOLDOFF-1.
  localparam int WT_W   = (RD_LAT  < 2)  ? 1 : $clog2(RD_LAT + 1);
  localparam int HOLD_W = (HOLDOFF <= 2) ? 1 : $clog2(HOLDOFF);
  localparam logic [WT_W-1:0]   WT_LAST   = WT_W'(RD_LAT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_WT_HI,
    S_RD_LO,
    S_WT_LO,
    S_SEND,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;       // next word address to read
  logic [LEN_W-1:0]  remain_q;     // words not yet read
  logic [WT_W-1:0]   wt_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [31:0]       hi_q;         // upper word waiting for its partner

  // Registered outputs
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [63:0]       tx_data_q;
  logic              tx_en_q;

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      wt_cnt_q   <= '0;
      hold_cnt_q <= '0;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      ram_addr_q <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only in the one
      // state that fires them; with non-blocking assignments the later write
      // in the case statement wins, so each pulse lasts exactly one cycle.
      rd_en_q <= 1'b0;
      tx_en_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (I_start) begin
            addr_q <= I_start_addr;
            busy_q <= 1'b1;
            remain_q <= I_len;
            state_q  <= (I_len == '0) ? S_DONE : S_RD_HI;
          end
        end

        // One read strobe, then advance the address (wrapping) and count.
        S_RD_HI, S_RD_LO: begin
          rd_en_q    <= 1'b1;
          ram_addr_q <= addr_q;
          addr_q     <= addr_q + ADDR_W'(1);
          remain_q   <= remain_q - LEN_W'(1);
          wt_cnt_q   <= '0;
          state_q    <= (state_q == S_RD_HI) ? S_WT_HI : S_WT_LO;
        end

        // The strobe is visible during the first wait cycle, so read data
        // is valid once the counter has reached RD_LAT.
        S_WT_HI: begin
          if (wt_cnt_q == WT_LAST) begin
            if (remain_q == '0) begin
              tx_data_q <= {bus.I_ram_rdata, PAD_WORD};
              state_q   <= S_SEND;
            end else begin
              hi_q    <= bus.I_ram_rdata;
              state_q <= S_RD_LO;
            end
          end else begin
            wt_cnt_q <= wt_cnt_q + WT_W'(1);
          end
        end

        S_WT_LO: begin
          if (wt_cnt_q == WT_LAST) begin
            tx_data_q <= {hi_q, bus.I_ram_rdata};
            state_q   <= S_SEND;
          end else begin
            wt_cnt_q <= wt_cnt_q + WT_W'(1);
          end
        end

        // tx_data_q is loaded only on entry to SEND, so the frame stays
        // put while the transmitter is busy and until the next frame.
        S_SEND: begin
          if (bus.I_tx_ready) begin
            tx_en_q    <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= S_HOLD;
          end
        end

        // The transmitter's ready may lag our pulse; ignore it for a while.
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= (remain_q != '0) ? S_RD_HI : S_DONE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        // First DONE cycle raises done/drops busy; second (done visible)
        // returns to IDLE, so a start seen alongside O_done is ignored.
        S_DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_busy          = busy_q;
  assign O_done          = done_q;
  assign bus.O_ram_rd_en = rd_en_q;
  assign bus.O_ram_addr  = ram_addr_q;
  assign bus.O_tx_data   = tx_data_q;
  assign bus.O_tx_en     = tx_en_q;

endmodule

// File: tb/tb_sysram_uart_dump.sv
// ---------------------------------------------------------------------------
// tb_sysram_uart_dump
//   Drives sysram_uart_dump against a 64K-word sysRAM model with a
//   configurable read latency and a ready-toggling transmitter. Expected
//   read addresses and frames are computed from the RAM contents, start
//   address and length alone.
// ---------------------------------------------------------------------------
module tb_sysram_uart_dump;

  localparam int          ADDR_W  = 16;
  localparam int          LEN_W   = 16;
  localparam int          RD_LAT  = 2;
  localparam int          HOLDOFF = 2;
  localparam logic [31:0] PAD     = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy;
  logic              done;

  sysram_uart_dump_if #(.ADDR_W(ADDR_W)) bus ();

  sysram_uart_dump #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .RD_LAT  (RD_LAT),
    .PAD_WORD(PAD),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .I_clk_10M   (clk),
    .I_rst_n     (rst_n),
    .I_start     (start),
    .I_start_addr(start_addr),
    .I_len       (len),
    .O_busy      (busy),
    .O_done      (done),
    .bus         (bus)
  );

  always #50 clk = ~clk;

  // sysRAM model: data appears RD_LAT cycles after the strobe and is only
  // valid for that one cycle (garbage otherwise).
  logic [31:0] mem [0:65535];
  logic [31:0] pipe [RD_LAT];

  always @(posedge clk) begin
    pipe[0] <= bus.O_ram_rd_en ? mem[bus.O_ram_addr] : 32'hDEAD_BEEF;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.I_ram_rdata = pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] rd_q [$];
  logic [63:0] tx_q [$];
  int          done_cnt;
  int          busy_drop;

  // Called once per falling edge while a transfer is in flight.
  task automatic sample();
    if (bus.O_ram_rd_en) rd_q.push_back(bus.O_ram_addr);
    if (bus.O_tx_en)     tx_q.push_back(bus.O_tx_data);
    if (done)            done_cnt++;
    else if (!busy)      busy_drop++;
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = ready low for a
  // long stall in SEND, then high. mid: pulse a foreign start mid-transfer.
  task automatic run_xfer(input logic [15:0] a, input logic [15:0] n,
                          input int mode, input bit mid);
    logic [15:0] exp_a [$];
    logic [63:0] exp_f [$];
    logic [15:0] wa, wb;
    logic [63:0] ref_data;
    int          cyc, done_at, stall_bad;

    for (int i = 0; i < int'(n); i++) begin
      wa = a + 16'(i);
      exp_a.push_back(wa);
    end
    for (int k = 0; k < int'(n); k += 2) begin
      wa = a + 16'(k);
      wb = a + 16'(k + 1);
      exp_f.push_back({mem[wa], (k + 1 < int'(n)) ? mem[wb] : PAD});
    end

    rd_q.delete();
    tx_q.delete();
    done_cnt  = 0;
    busy_drop = 0;
    done_at   = -1;
    stall_bad = 0;
    ref_data  = '0;
    bus.I_tx_ready = (mode == 2) ? 1'b0 : 1'b1;

    @(negedge clk);
    start = 1'b1; start_addr = a; len = n;
    @(negedge clk);
    start = 1'b0; start_addr = 16'($urandom); len = 16'($urandom);
    sample();
    check("busy_after_start", busy, 1'b1);

    cyc = 1;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) bus.I_tx_ready = ($urandom_range(0, 3) != 0);
      if (mid && cyc == 5) begin
        start = 1'b1; start_addr = a + 16'h0100; len = 16'd1;
      end else if (mid && cyc == 6) begin
        start = 1'b0;
      end
      sample();
      if (mode == 2) begin
        if (cyc == 20) ref_data = bus.O_tx_data;
        if (cyc > 20 && cyc <= 70 && (bus.O_tx_data !== ref_data || bus.O_tx_en))
          stall_bad++;
        if (cyc == 70) begin
          check("no_tx_while_stalled", 64'(tx_q.size()), 64'd0);
          bus.I_tx_ready = 1'b1;
        end
        if (cyc == 71) check("tx_en_after_ready", bus.O_tx_en, 1'b1);
      end
      if (done_cnt != 0 && done_at < 0) done_at = cyc;
    end

    check("done_seen", 64'(done_cnt), 64'd1);
    if (n == 0) check("len0_done_latency", 64'(done_at), 64'd2);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
    check("busy_held", 64'(busy_drop), 64'd0);

    check("read_count", 64'(rd_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < rd_q.size() && i < exp_a.size(); i++)
      check("read_addr", rd_q[i], exp_a[i]);
    check("frame_count", 64'(tx_q.size()), 64'(exp_f.size()));
    for (int i = 0; i < tx_q.size() && i < exp_f.size(); i++)
      check("frame", tx_q[i], exp_f[i]);

    if (mode == 2) begin
      check("stall_stable", 64'(stall_bad), 64'd0);
      check("stall_frame", ref_data, exp_f[0]);
    end
    bus.I_tx_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.I_tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",     busy, 1'b0);
    check("rst_done",     done, 1'b0);
    check("rst_rd_en",    bus.O_ram_rd_en, 1'b0);
    check("rst_ram_addr", bus.O_ram_addr, 16'h0);
    check("rst_tx_data",  bus.O_tx_data, 64'h0);
    check("rst_tx_en",    bus.O_tx_en, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two full frames with the reference pattern.
    run_xfer(16'h0010, 16'd4, 0, 1'b0);
    if (tx_q.size() == 2) begin
      check("t1_frame0", tx_q[0], 64'hA000_0010_A000_0011);
      check("t1_frame1", tx_q[1], 64'hA000_0012_A000_0013);
    end

    // Odd length: last frame padded.
    run_xfer(16'h0020, 16'd3, 0, 1'b0);
    if (tx_q.size() == 2) check("t2_pad_frame", tx_q[1], 64'hA000_0022_0000_0000);

    // Address wrap.
    run_xfer(16'hFFFF, 16'd2, 0, 1'b0);
    if (tx_q.size() == 1) check("t3_wrap_frame", tx_q[0], 64'hA000_FFFF_A000_0000);

    // Transmitter stall.
    run_xfer(16'h0040, 16'd2, 2, 1'b0);

    // Ignored mid-transfer start, then zero length.
    run_xfer(16'h0050, 16'd6, 0, 1'b1);
    run_xfer(16'h0060, 16'd0, 0, 1'b0);

    // Reset while waiting for the low word.
    rd_q.delete(); tx_q.delete(); done_cnt = 0; busy_drop = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 16'h0070; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && rd_q.size() < 2; c++) begin
      @(negedge clk);
      sample();
    end
    check("t6_reached_wt_lo", 64'(rd_q.size()), 64'd2);
    #10 rst_n = 1'b0;
    #1;
    check("t6_rst_busy",     busy, 1'b0);
    check("t6_rst_done",     done, 1'b0);
    check("t6_rst_rd_en",    bus.O_ram_rd_en, 1'b0);
    check("t6_rst_ram_addr", bus.O_ram_addr, 16'h0);
    check("t6_rst_tx_data",  bus.O_tx_data, 64'h0);
    check("t6_rst_tx_en",    bus.O_tx_en, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    check("t6_no_done", 64'(done_cnt), 64'd0);
    check("t6_no_frame", 64'(tx_q.size()), 64'd0);
    run_xfer(16'h0080, 16'd5, 0, 1'b0);

    // Random contents, addresses, lengths and transmitter readiness.
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int t = 0; t < 12; t++) begin
      logic [15:0] ra, rn;
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
      rn = 16'($urandom_range(0, 9));
      run_xfer(ra, rn, 1, (rn >= 16'd4) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
